cnn_mac_pipe: RTL and testbench
===============================

Name: cnn_mac_pipe

Overview:
Parametrised, pipelined signed multiply-accumulate unit. It succeeds the fixed 10s x 14s combinational DSP48 multiplier wrapper. Adds configurable operand widths, a configurable multiplier pipeline depth, valid/ready handshaking with backpressure, and dot-product accumulation with rounding, shift and saturation. Sits between the line-buffer/weight fetch and the activation stage of the conv layers.

Parameters:
DIN0_WIDTH, 10, signed activation operand width
DIN1_WIDTH, 14, signed weight operand width
ACC_WIDTH, 32, signed accumulator width; must be >= DIN0_WIDTH+DIN1_WIDTH
DOUT_WIDTH, 16, signed result width after shift/saturate
MUL_STAGES, 2, register stages in multiplier path (1..4)
SHIFT, 8, arithmetic right shift applied to accumulator at output (0..ACC_WIDTH-1)
ACC_EN, 1, 1 = accumulate between first/last; 0 = every beat treated as first and last (pure pipelined multiplier)

Ports:
ap_clk  in  1  clock, rising edge
ap_rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  unit can accept beat
din0  in  DIN0_WIDTH  signed activation
din1  in  DIN1_WIDTH  signed weight
in_first  in  1  beat starts new accumulation (replaces acc)
in_last  in  1  beat ends accumulation; result emitted
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
dout  out  DOUT_WIDTH  rounded, shifted, saturated result
dout_sat  out  1  dout was clipped to max/min

Behaviour:
- Reset (async assert, sync deassert handled upstream): all stage valids 0, accumulator 0, out_valid 0, dout 0, dout_sat 0. in_ready is 1 from the first cycle after reset.
- Stall = out_valid & ~out_ready. in_ready = ~stall. While stall, all pipeline registers and the accumulator hold. Beats are never dropped or duplicated.
- Accept: in_valid & in_ready. The product, first and last flags enter stage 1.
- Product: full-precision signed din0*din1 (DIN0_WIDTH+DIN1_WIDTH bits), sign-extended to ACC_WIDTH. Carried through MUL_STAGES registers with its first/last/valid tags.
- Accumulate stage, on a valid tagged product p:
  - acc_next = first ? p : acc + p.
  - Addition wraps at ACC_WIDTH (two's complement). No overflow detection in the accumulator.
  - acc <= acc_next.
  - If last: the output register loads from acc_next.
- Output computation:
  - r = (acc_next + (SHIFT>0 ? 2^(SHIFT-1) : 0)) >>> SHIFT. This is round-half-up, computed at ACC_WIDTH+1 bits so the round add cannot wrap.
  - If r > 2^(DOUT_WIDTH-1)-1: dout = max, dout_sat = 1.
  - If r < -2^(DOUT_WIDTH-1): dout = min, dout_sat = 1.
  - Otherwise dout = r, dout_sat = 0.
- Latency: a last beat accepted in cycle N gives out_valid=1 in cycle N+MUL_STAGES+1, absent stalls. Throughput is 1 beat/cycle.
- out_valid/dout/dout_sat are held stable until out_ready. Cleared the cycle after the handshake unless a new result loads in the same cycle, in which case out_valid stays 1.
- Boundaries:
  - first and last on the same beat: single-product result.
  - last without a preceding first: adds onto the current acc (0 after reset).
  - first while a previous group is unterminated: prior partial sum is discarded silently.
  - in_valid=0 bubbles pass through without touching acc.
  - ACC_EN=0: in_first/in_last are ignored and forced to 1.
  - Reset mid-group or mid-stall: everything cleared, and in-flight beats are lost.

Test Plan:
- ACC_EN=0, SHIFT=0, DOUT_WIDTH=24: din0=-512, din1=8191 -> dout=-4193792 after MUL_STAGES+1 cycles, dout_sat=0. Back-to-back beats give one result per cycle.
- Dot product, SHIFT=0: beats (3,4,first),(-2,5),(10,10,last) -> single result dout=102 exactly once.
- Rounding, SHIFT=8: single beat 3*128=384 -> dout=2 (384/256=1.5 rounds up). Single beat -3*128 -> dout=-1.
- Saturation, SHIFT=0, DOUT_WIDTH=16: 511*8191 -> dout=32767, dout_sat=1. -512*8191 -> dout=-32768, dout_sat=1.
- Backpressure: hold out_ready=0 for 5 cycles with a continuous input stream -> in_ready=0 during the stall, dout stable, no beats lost. Results match the golden model in order after release.
- Reset asserted mid-group with 2 beats in flight -> out_valid=0, acc=0. Next group (2,2,first+last) yields dout=4.

Source files
------------

// File: rtl/cnn_mac_pipe.sv
// Pipelined signed multiply-accumulate with valid/ready handshake and round/shift/saturate output.
// Products carry first/last tags through MUL_STAGES registers; the output register holds under backpressure.
module cnn_mac_pipe #(
   parameter int DIN0_WIDTH = 10,
   parameter int DIN1_WIDTH = 14,
   parameter int ACC_WIDTH  = 32,
   parameter int DOUT_WIDTH = 16,
   parameter int MUL_STAGES = 2,
   parameter int SHIFT      = 8,
   parameter bit ACC_EN     = 1'b1
) (
   input  logic                         ap_clk,
   input  logic                         ap_rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic signed [DIN0_WIDTH-1:0] din0,
   input  logic signed [DIN1_WIDTH-1:0] din1,
   input  logic                         in_first,
   input  logic                         in_last,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic signed [DOUT_WIDTH-1:0] dout,
   output logic                         dout_sat
);

   localparam int PROD_WIDTH = DIN0_WIDTH + DIN1_WIDTH;
   localparam int LAST_STAGE = MUL_STAGES - 1;
   localparam int RND_POS    = (SHIFT > 0) ? SHIFT - 1 : 0;
   localparam logic signed [ACC_WIDTH:0] RND =
      (SHIFT > 0) ? ({{ACC_WIDTH{1'b0}}, 1'b1} << RND_POS) : {(ACC_WIDTH+1){1'b0}};
   localparam logic signed [ACC_WIDTH:0] DMAX =
      {{(ACC_WIDTH+2-DOUT_WIDTH){1'b0}}, {(DOUT_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH:0] DMIN =
      {{(ACC_WIDTH+2-DOUT_WIDTH){1'b1}}, {(DOUT_WIDTH-1){1'b0}}};

   // Round half up one bit wider than the accumulator, then clip; MSB of the result is the clip flag.
   function automatic logic [DOUT_WIDTH:0] round_sat(input logic signed [ACC_WIDTH-1:0] a);
      logic signed [ACC_WIDTH:0] r;
      r = ($signed({a[ACC_WIDTH-1], a}) + RND) >>> SHIFT;
      if (r > DMAX) begin
         round_sat = {1'b1, DMAX[DOUT_WIDTH-1:0]};
      end else if (r < DMIN) begin
         round_sat = {1'b1, DMIN[DOUT_WIDTH-1:0]};
      end else begin
         round_sat = {1'b0, r[DOUT_WIDTH-1:0]};
      end
   endfunction

   logic                         stall_s;
   logic signed [PROD_WIDTH-1:0] prod_s;
   logic                         first_s;
   logic                         last_s;
   logic signed [ACC_WIDTH-1:0]  pipe_prod_r [MUL_STAGES];
   logic [MUL_STAGES-1:0]        pipe_vld_r;
   logic [MUL_STAGES-1:0]        pipe_first_r;
   logic [MUL_STAGES-1:0]        pipe_last_r;
   logic signed [ACC_WIDTH-1:0]  acc_r;
   logic signed [ACC_WIDTH-1:0]  acc_next_s;
   logic [DOUT_WIDTH:0]          res_s;
   logic                         out_valid_r;
   logic signed [DOUT_WIDTH-1:0] dout_r;
   logic                         dout_sat_r;

   assign stall_s   = out_valid_r & ~out_ready;
   assign in_ready  = ~stall_s;
   assign out_valid = out_valid_r;
   assign dout      = dout_r;
   assign dout_sat  = dout_sat_r;

   // Input product and group tags; with accumulation disabled every beat is a whole group.
   always_comb begin
      prod_s  = PROD_WIDTH'(din0) * PROD_WIDTH'(din1);
      first_s = 1'b1;
      last_s  = 1'b1;
      if (ACC_EN) begin
         first_s = in_first;
         last_s  = in_last;
      end else begin
         first_s = 1'b1;
         last_s  = 1'b1;
      end
   end

   // Multiplier pipeline: advances as a whole unless the output is stalled.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         for (int i = 0; i < MUL_STAGES; i++) begin
            pipe_prod_r[i] <= '0;
         end
         pipe_vld_r   <= '0;
         pipe_first_r <= '0;
         pipe_last_r  <= '0;
      end else if (!stall_s) begin
         pipe_prod_r[0]  <= ACC_WIDTH'(prod_s);
         pipe_vld_r[0]   <= in_valid;
         pipe_first_r[0] <= first_s;
         pipe_last_r[0]  <= last_s;
         for (int i = 1; i < MUL_STAGES; i++) begin
            pipe_prod_r[i]  <= pipe_prod_r[i-1];
            pipe_vld_r[i]   <= pipe_vld_r[i-1];
            pipe_first_r[i] <= pipe_first_r[i-1];
            pipe_last_r[i]  <= pipe_last_r[i-1];
         end
      end
   end

   // Next accumulator value and its rounded/saturated output form.
   always_comb begin
      acc_next_s = '0;
      if (pipe_first_r[LAST_STAGE]) begin
         acc_next_s = pipe_prod_r[LAST_STAGE];
      end else begin
         acc_next_s = acc_r + pipe_prod_r[LAST_STAGE];
      end
      res_s = round_sat(acc_next_s);
   end

   // Accumulator: bubbles and stalls leave it untouched.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         acc_r <= '0;
      end else if (!stall_s && pipe_vld_r[LAST_STAGE]) begin
         acc_r <= acc_next_s;
      end
   end

   // Output register: loads on a tagged last product, clears after a handshake with nothing new.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         out_valid_r <= 1'b0;
         dout_r      <= '0;
         dout_sat_r  <= 1'b0;
      end else if (!stall_s) begin
         if (pipe_vld_r[LAST_STAGE] && pipe_last_r[LAST_STAGE]) begin
            out_valid_r <= 1'b1;
            dout_r      <= res_s[DOUT_WIDTH-1:0];
            dout_sat_r  <= res_s[DOUT_WIDTH];
         end else begin
            out_valid_r <= 1'b0;
            dout_r      <= '0;
            dout_sat_r  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_cnn_mac_pipe.sv
// Randomised bench for cnn_mac_pipe: an accumulating instance with backpressure and a pure
// multiplier instance, both scored against queue-based arithmetic models.
module tb_cnn_mac_pipe;

   localparam int SH_A = 8;
   localparam int DW_A = 16;
   localparam int MS_A = 2;
   localparam int SH_B = 0;
   localparam int DW_B = 24;
   localparam int MS_B = 3;

   typedef struct {
      int d;
      bit s;
      int cyc;
      int stc;
   } res_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic in_valid = 1'b0;
   logic in_first = 1'b0;
   logic in_last = 1'b0;
   logic out_ready = 1'b1;
   logic signed [9:0]  din0 = '0;
   logic signed [13:0] din1 = '0;

   logic in_ready_a, out_valid_a, dout_sat_a;
   logic signed [DW_A-1:0] dout_a;
   logic in_ready_b, out_valid_b, dout_sat_b;
   logic signed [DW_B-1:0] dout_b;

   res_t qa[$];
   res_t qb[$];
   int sum_a = 0;
   int cyc = 0;
   int stall_cnt = 0;
   int n_checks = 0;
   int n_pass = 0;
   int or_mode = 0;
   bit prev_stall = 1'b0;
   logic signed [DW_A-1:0] held_dout = '0;
   int last_a = 0;
   int last_sat_a = 0;
   int last_b = 0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   cnn_mac_pipe #(
      .DIN0_WIDTH(10), .DIN1_WIDTH(14), .ACC_WIDTH(32), .DOUT_WIDTH(DW_A),
      .MUL_STAGES(MS_A), .SHIFT(SH_A), .ACC_EN(1'b1)
   ) u_dut_a (
      .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
      .din0(din0), .din1(din1), .in_first(in_first), .in_last(in_last),
      .out_valid(out_valid_a), .out_ready(out_ready), .dout(dout_a), .dout_sat(dout_sat_a)
   );

   cnn_mac_pipe #(
      .DIN0_WIDTH(10), .DIN1_WIDTH(14), .ACC_WIDTH(32), .DOUT_WIDTH(DW_B),
      .MUL_STAGES(MS_B), .SHIFT(SH_B), .ACC_EN(1'b0)
   ) u_dut_b (
      .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
      .din0(din0), .din1(din1), .in_first(in_first), .in_last(in_last),
      .out_valid(out_valid_b), .out_ready(1'b1), .dout(dout_b), .dout_sat(dout_sat_b)
   );

   task automatic check(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   // Expected output: floor((s + half LSB) / 2^sh), clipped to a dw-bit signed range.
   function automatic res_t model_res(input longint s, input int sh, input int dw);
      res_t e;
      longint half, r, mx;
      half = (longint'(1) << sh) / 2;
      r    = (s + half) >>> sh;
      mx   = (longint'(1) << (dw - 1)) - 1;
      e.cyc = 0;
      e.stc = 0;
      if (r > mx) begin
         e.d = int'(mx); e.s = 1'b1;
      end else if (r < -mx - 1) begin
         e.d = int'(-mx - 1); e.s = 1'b1;
      end else begin
         e.d = int'(r); e.s = 1'b0;
      end
      return e;
   endfunction

   // Scoreboard for the accumulating instance, plus stall behaviour checks.
   always @(negedge clk) begin
      res_t e;
      int p;
      bit stall;
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (in_valid && in_ready_a) begin
            p = int'(din0) * int'(din1);
            if (in_first) sum_a = p;
            else sum_a = sum_a + p;
            if (in_last) begin
               e = model_res(longint'(sum_a), SH_A, DW_A);
               e.cyc = cyc;
               e.stc = stall_cnt;
               qa.push_back(e);
            end
         end
         stall = out_valid_a && !out_ready;
         if (stall) begin
            stall_cnt++;
            check("a_in_ready_stall", longint'(in_ready_a), 0);
            if (prev_stall) check("a_dout_hold", longint'(dout_a), longint'(held_dout));
            held_dout = dout_a;
         end
         prev_stall = stall;
         if (out_valid_a && out_ready) begin
            if (qa.size() == 0) begin
               check("a_unexpected_result", longint'(qa.size()), 1);
            end else begin
               e = qa.pop_front();
               check("a_dout", longint'(dout_a), longint'(e.d));
               check("a_sat", longint'(dout_sat_a), longint'(e.s));
               if (e.stc == stall_cnt) check("a_latency", longint'(cyc - e.cyc), MS_A + 1);
               last_a = int'(dout_a);
               last_sat_a = int'(dout_sat_a);
            end
         end
      end
   end

   // Scoreboard for the pure multiplier instance: one result per valid beat.
   always @(negedge clk) begin
      res_t e;
      if (rst_n) begin
         if (in_valid) begin
            check("b_in_ready", longint'(in_ready_b), 1);
            e = model_res(longint'(int'(din0) * int'(din1)), SH_B, DW_B);
            e.cyc = cyc;
            qb.push_back(e);
         end
         if (out_valid_b) begin
            if (qb.size() == 0) begin
               check("b_unexpected_result", longint'(qb.size()), 1);
            end else begin
               e = qb.pop_front();
               check("b_dout", longint'(dout_b), longint'(e.d));
               check("b_sat", longint'(dout_sat_b), longint'(e.s));
               check("b_latency", longint'(cyc - e.cyc), MS_B + 1);
               last_b = int'(dout_b);
            end
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (or_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
         endcase
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input int d0, input int d1, input bit f, input bit l);
      int n;
      din0 = 10'(d0);
      din1 = 14'(d1);
      in_first = f;
      in_last = l;
      in_valid = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!in_ready_a && n < 100);
      if (!in_ready_a) check("send_ready_timeout", longint'(in_ready_a), 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((qa.size() != 0 || qb.size() != 0) && n < 300) begin
         idle(1);
         n++;
      end
      check("drain_pending", longint'(qa.size() + qb.size()), 0);
      idle(2);
   endtask

   task automatic rand_beat(input bit f, input bit l);
      send(int'($urandom_range(0, 1023)) - 512, int'($urandom_range(0, 16383)) - 8192, f, l);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got %0d checks expected completion", n_checks);
      $fatal(1);
   end

   initial begin
      int st0, len;
      bit skip_first;
      idle(3);
      check("rst_out_valid_a", longint'(out_valid_a), 0);
      check("rst_dout_a", longint'(dout_a), 0);
      check("rst_dout_sat_a", longint'(dout_sat_a), 0);
      check("rst_in_ready_a", longint'(in_ready_a), 1);
      check("rst_out_valid_b", longint'(out_valid_b), 0);
      rst_n = 1'b1;
      idle(1);
      check("post_rst_in_ready_a", longint'(in_ready_a), 1);

      send(-512, 8191, 1'b1, 1'b1);
      drain();
      check("b_full_product", longint'(last_b), -4193792);
      for (int i = 0; i < 6; i++) rand_beat(1'b1, 1'b1);
      drain();

      send(3, 4, 1'b1, 1'b0);
      send(-2, 5, 1'b0, 1'b0);
      send(10, 10, 1'b0, 1'b1);
      drain();

      send(3, 128, 1'b1, 1'b1);
      drain();
      check("round_pos", longint'(last_a), 2);
      send(-3, 128, 1'b1, 1'b1);
      drain();
      check("round_neg", longint'(last_a), -1);

      for (int i = 0; i < 3; i++) send(511, 8191, i == 0, i == 2);
      drain();
      check("sat_max", longint'(last_a), 32767);
      check("sat_max_flag", longint'(last_sat_a), 1);
      for (int i = 0; i < 3; i++) send(-512, 8191, i == 0, i == 2);
      drain();
      check("sat_min", longint'(last_a), -32768);
      check("sat_min_flag", longint'(last_sat_a), 1);

      st0 = stall_cnt;
      or_mode = 2;
      fork
         for (int i = 0; i < 12; i++) rand_beat(1'b1, 1'b1);
         begin
            idle(8);
            or_mode = 0;
         end
      join
      drain();
      check("stall_seen", longint'(stall_cnt - st0 >= 4), 1);

      send(50, 60, 1'b1, 1'b0);
      send(70, 80, 1'b0, 1'b0);
      rst_n = 1'b0;
      sum_a = 0;
      qa.delete();
      qb.delete();
      idle(2);
      check("midrst_out_valid_a", longint'(out_valid_a), 0);
      check("midrst_out_valid_b", longint'(out_valid_b), 0);
      rst_n = 1'b1;
      idle(1);
      send(100, 100, 1'b0, 1'b1);
      drain();
      check("acc_cleared", longint'(last_a), 39);
      send(2, 2, 1'b1, 1'b1);
      drain();
      check("b_after_rst", longint'(last_b), 4);

      or_mode = 1;
      for (int g = 0; g < 60; g++) begin
         len = int'($urandom_range(1, 5));
         skip_first = ($urandom_range(0, 7) == 0);
         for (int j = 0; j < len; j++) begin
            rand_beat((j == 0) && !skip_first, j == len - 1);
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
         end
      end
      or_mode = 0;
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
